// File: rtl/data_flow_model_pkg.sv
// Shared command/message codes and defaults for the two-doctor allotment controller.
package data_flow_model_pkg;

  localparam int unsigned CONSULT_CYCLES_DEF = 15;

  typedef enum logic [1:0] {
    Q_ADMIT  = 2'd0,
    Q_REL1   = 2'd1,
    Q_REL2   = 2'd2,
    Q_STATUS = 2'd3
  } query_e;

  typedef enum logic [1:0] {
    M_NONE = 2'd0,
    M_DOC1 = 2'd1,
    M_DOC2 = 2'd2,
    M_WAIT = 2'd3
  } message_e;

endpackage

// File: rtl/data_flow_model_doctor_slot.sv
// One doctor: busy flag plus consultation countdown; o_expire_c flags the edge on
// which the current consultation ends.
module doctor_slot #(
  parameter int unsigned CONSULT_CYCLES = 15,
  parameter int unsigned CNT_W          = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_release,
  output logic o_busy,
  output logic o_expire_c
);

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;

  assign o_busy     = r_busy;
  assign o_expire_c = r_busy && (r_cnt == CNT_W'(1));

  // Load beats release; a load on the expiry edge simply restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_busy <= 1'b1;
      r_cnt  <= CNT_W'(CONSULT_CYCLES);
    end else if (i_release) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (r_busy) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (o_expire_c) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/data_flow_model.sv
// Two-doctor allotment controller: decodes ADMIT/RELEASE/STATUS and reports on message.
// Optional single-entry wait queue enabled by defining DATA_FLOW_MODEL_WAITQ_EN.
module data_flow_model
  import data_flow_model_pkg::*;
#(
  parameter int unsigned CONSULT_CYCLES = CONSULT_CYCLES_DEF,
  parameter int unsigned CNT_W          = $clog2(CONSULT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] query,
  output logic       A,
  output logic       B,
`ifdef DATA_FLOW_MODEL_WAITQ_EN
  output logic       pending,
`endif
  output logic [1:0] message
);

  logic       w_busy1, w_busy2;
  logic       w_exp1, w_exp2;
  logic       w_load1, w_load2;
  logic       w_rel1, w_rel2;
  logic       w_free1, w_free2;
  logic [1:0] w_msg_nxt;
  logic [1:0] r_message;

  doctor_slot #(.CONSULT_CYCLES(CONSULT_CYCLES), .CNT_W(CNT_W)) u_doc1 (
    .clk(clk), .rst_n(rst_n), .i_load(w_load1), .i_release(w_rel1),
    .o_busy(w_busy1), .o_expire_c(w_exp1)
  );

  doctor_slot #(.CONSULT_CYCLES(CONSULT_CYCLES), .CNT_W(CNT_W)) u_doc2 (
    .clk(clk), .rst_n(rst_n), .i_load(w_load2), .i_release(w_rel2),
    .o_busy(w_busy2), .o_expire_c(w_exp2)
  );

`ifdef DATA_FLOW_MODEL_WAITQ_EN
  logic r_pending;
  logic w_pending_nxt;
  assign pending = r_pending;
`endif

  // Order per edge: expiry, release, pending patient, then the new ADMIT/STATUS.
  always_comb begin
    w_load1   = 1'b0;
    w_load2   = 1'b0;
    w_rel1    = 1'b0;
    w_rel2    = 1'b0;
    w_free1   = !w_busy1 || w_exp1;
    w_free2   = !w_busy2 || w_exp2;
    w_msg_nxt = r_message;
`ifdef DATA_FLOW_MODEL_WAITQ_EN
    w_pending_nxt = r_pending;
`endif
    if (start && (query == Q_REL1)) begin
      w_rel1    = 1'b1;
      w_free1   = 1'b1;
      w_msg_nxt = M_NONE;
    end
    if (start && (query == Q_REL2)) begin
      w_rel2    = 1'b1;
      w_free2   = 1'b1;
      w_msg_nxt = M_NONE;
    end
`ifdef DATA_FLOW_MODEL_WAITQ_EN
    if (r_pending) begin
      if (w_free1) begin
        w_load1       = 1'b1;
        w_rel1        = 1'b0;
        w_free1       = 1'b0;
        w_msg_nxt     = M_DOC1;
        w_pending_nxt = 1'b0;
      end else if (w_free2) begin
        w_load2       = 1'b1;
        w_rel2        = 1'b0;
        w_free2       = 1'b0;
        w_msg_nxt     = M_DOC2;
        w_pending_nxt = 1'b0;
      end
    end
`endif
    if (start && (query == Q_ADMIT)) begin
      if (w_free1) begin
        w_load1   = 1'b1;
        w_free1   = 1'b0;
        w_msg_nxt = M_DOC1;
      end else if (w_free2) begin
        w_load2   = 1'b1;
        w_free2   = 1'b0;
        w_msg_nxt = M_DOC2;
      end else begin
        w_msg_nxt = M_WAIT;
`ifdef DATA_FLOW_MODEL_WAITQ_EN
        w_pending_nxt = 1'b1;
`endif
      end
    end
    if (start && (query == Q_STATUS)) begin
      w_msg_nxt = (!w_free1 && !w_free2) ? M_WAIT : M_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_message <= M_NONE;
    end else begin
      r_message <= w_msg_nxt;
    end
  end

`ifdef DATA_FLOW_MODEL_WAITQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end
`endif

  assign A       = w_busy1;
  assign B       = w_busy2;
  assign message = r_message;

endmodule

// File: tb/tb_data_flow_model.sv
// Randomized + directed bench for data_flow_model against a remaining-time reference model.
module tb_data_flow_model;
  import data_flow_model_pkg::*;

  localparam int CC = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] query = 2'd0;
  logic       A, B;
  logic [1:0] message;
`ifdef DATA_FLOW_MODEL_WAITQ_EN
  logic       pending;
`endif

  always #5 clk = ~clk;

  data_flow_model #(.CONSULT_CYCLES(CC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .query(query),
    .A(A), .B(B),
`ifdef DATA_FLOW_MODEL_WAITQ_EN
    .pending(pending),
`endif
    .message(message)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: cycles of consultation left per doctor (0 = free).
  int m_rem1 = 0, m_rem2 = 0, m_msg = 0, m_pend = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rem1 = 0; m_rem2 = 0; m_msg = 0; m_pend = 0;
  endtask

  task automatic model_step(input bit st, input int q);
    int r1, r2;
    r1 = (m_rem1 > 0) ? m_rem1 - 1 : 0;
    r2 = (m_rem2 > 0) ? m_rem2 - 1 : 0;
    if (st && q == 1) begin r1 = 0; m_msg = 0; end
    if (st && q == 2) begin r2 = 0; m_msg = 0; end
`ifdef DATA_FLOW_MODEL_WAITQ_EN
    if (m_pend != 0) begin
      if (r1 == 0)      begin r1 = CC; m_msg = 1; m_pend = 0; end
      else if (r2 == 0) begin r2 = CC; m_msg = 2; m_pend = 0; end
    end
`endif
    if (st && q == 0) begin
      if (r1 == 0)      begin r1 = CC; m_msg = 1; end
      else if (r2 == 0) begin r2 = CC; m_msg = 2; end
      else begin
        m_msg = 3;
`ifdef DATA_FLOW_MODEL_WAITQ_EN
        m_pend = 1;
`endif
      end
    end
    if (st && q == 3) m_msg = (r1 > 0 && r2 > 0) ? 3 : 0;
    m_rem1 = r1;
    m_rem2 = r2;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".A"}, 8'(A), 8'(m_rem1 > 0));
    chk({tag, ".B"}, 8'(B), 8'(m_rem2 > 0));
    chk({tag, ".message"}, 8'(message), 8'(m_msg));
`ifdef DATA_FLOW_MODEL_WAITQ_EN
    chk({tag, ".pending"}, 8'(pending), 8'(m_pend));
`endif
  endtask

  task automatic cycle(input bit st, input logic [1:0] q, input string tag);
    @(negedge clk);
    start = st;
    query = q;
    @(posedge clk);
    model_step(st, int'(q));
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    start = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single admit: doctor 1 for exactly CC cycles.
    cycle(1'b1, Q_ADMIT, "admit1");
    chk("admit1.msg_const", 8'(message), 8'd1);
    idle(CC + 1, "admit1_run");
    chk("admit1.freed", 8'(A), 8'd0);

    // Back-to-back admits: D1, D2, wait.
    cycle(1'b1, Q_ADMIT, "b2b0");
    cycle(1'b1, Q_ADMIT, "b2b1");
    cycle(1'b1, Q_ADMIT, "b2b2");
    chk("b2b.wait_const", 8'(message), 8'd3);
    cycle(1'b1, Q_STATUS, "b2b_status");
    cycle(1'b1, Q_REL2, "rel2");
    cycle(1'b1, Q_ADMIT, "readmit2");
    idle(CC + 2, "b2b_run");

    // Admit exactly on the expiry edge keeps the flag high.
    cycle(1'b1, Q_ADMIT, "exp0");
    idle(CC - 1, "exp_wait");
    cycle(1'b1, Q_ADMIT, "exp_edge");
    chk("exp_edge.A_const", 8'(A), 8'd1);
    idle(CC + 1, "exp_run");

    // Release on the expiry edge.
    cycle(1'b1, Q_ADMIT, "relexp0");
    idle(CC - 1, "relexp_wait");
    cycle(1'b1, Q_REL1, "relexp_edge");

    // Async reset mid-consultation.
    cycle(1'b1, Q_ADMIT, "pre_rst0");
    cycle(1'b1, Q_ADMIT, "pre_rst1");
    cycle(1'b1, Q_ADMIT, "pre_rst2");
    do_reset("midrst");

    // Random traffic, ADMIT-heavy so both doctors saturate.
    for (int i = 0; i < 800; i++) begin
      bit         st;
      logic [1:0] q;
      st = ($urandom_range(0, 3) != 0);
      q  = ($urandom_range(0, 1) != 0) ? 2'd0 : 2'($urandom_range(0, 3));
      cycle(st, q, "rand");
      if (i == 400) do_reset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
